// File: rtl/vga_ctrl_pkg.sv
// Shared types and video timing constants for the VGA mode-switch controller
// and the dynamic timing generator it supervises.
package vga_ctrl_pkg;

   typedef enum logic [2:0] {
      BOOT    = 3'd0,
      IDLE    = 3'd1,
      WAIT_VS = 3'd2,
      HOLD    = 3'd3,
      SETTLE  = 3'd4,
      MUTE    = 3'd5
   } state_t;

   localparam logic MODE_720P30  = 1'b0;
   localparam logic MODE_1080P60 = 1'b1;

   // 1080p60 on 148.5 MHz, 720p30 on 37.125 MHz (CEA-861 totals)
   localparam int H1080_ACTIVE = 1920;
   localparam int H1080_TOTAL  = 2200;
   localparam int V1080_ACTIVE = 1080;
   localparam int V1080_TOTAL  = 1125;
   localparam int H720_ACTIVE  = 1280;
   localparam int H720_TOTAL   = 1650;
   localparam int V720_ACTIVE  = 720;
   localparam int V720_TOTAL   = 750;

   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Brings the generator's vsync_n into the control clock domain and flags each
// falling edge with a one-cycle pulse.
module vga_sync_edge
   import vga_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic async_n_i,
   output logic vs_edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [1:0]             hist_q;

   // Synchronizer chain and edge history; idle level of vsync_n is high
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync_q <= '1;
         hist_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_n_i};
         hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
      end
   end

   assign vs_edge_o = hist_q[1] & ~hist_q[0];

endmodule

// File: rtl/vga_mode_switch_ctrl.sv
// Sequences VGA resolution changes: frame-aligned reset, clock-mux settle, muted frames.
// Build option VGA_MODE_FALLBACK_EN: revert to the previous mode once if the new one yields no vsync.
module vga_mode_switch_ctrl
   import vga_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 1024,
   parameter int MUTE_FRAMES    = 2,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic clk_37m,
   input  logic resetn,
   input  logic req_valid,
   input  logic req_mode,
   output logic req_ready,
   input  logic vsync_n_in,
   output logic mode_sel,
   output logic vga_resetn,
   output logic pix_en,
   output logic busy,
   output logic timeout_err
`ifdef VGA_MODE_FALLBACK_EN
   ,
   output logic fallback_active
`endif
);

   localparam int SW = cnt_w(SETTLE_CYCLES);
   localparam int FW = cnt_w(MUTE_FRAMES);
   localparam int TW = cnt_w(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [FW-1:0] FRM_LAST    = FW'(MUTE_FRAMES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic [SW-1:0] set_cnt_q, set_cnt_d;
   logic [FW-1:0] frm_cnt_q, frm_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          pend_q, pend_d;
   logic          mode_q, mode_d;
   logic          terr_q, terr_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;
   logic          pix_q, pix_d;
   logic          vrst_q, vrst_d;
   logic          vs_edge;
`ifdef VGA_MODE_FALLBACK_EN
   logic          prev_q, prev_d;
   logic          fb_q, fb_d;
`endif

   vga_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk_i     (clk_37m),
      .rst_n_i   (resetn),
      .async_n_i (vsync_n_in),
      .vs_edge_o (vs_edge)
   );

   // Next-state logic, mode latching and sticky timeout flag
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      mode_d  = mode_q;
      terr_d  = terr_q;
`ifdef VGA_MODE_FALLBACK_EN
      prev_d  = prev_q;
      fb_d    = fb_q;
`endif
      case (state_q)
         BOOT, SETTLE: begin
            if (set_cnt_q == SETTLE_LAST) state_d = MUTE;
            else                          state_d = state_q;
         end
         IDLE: begin
            if (req_valid && (req_mode != mode_q)) begin
               pend_d  = req_mode;
               state_d = WAIT_VS;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_VS: begin
            if (vs_edge) begin
               state_d = HOLD;
            end else if (tmo_cnt_q == TMO_LAST) begin
               terr_d  = 1'b1;
               state_d = HOLD;
            end else begin
               state_d = WAIT_VS;
            end
         end
         HOLD: begin
            // Generator reset has been low for a cycle; now the clock mux may move
            mode_d  = pend_q;
            state_d = SETTLE;
`ifdef VGA_MODE_FALLBACK_EN
            prev_d  = mode_q;
`endif
         end
         MUTE: begin
            if (vs_edge) begin
               if (frm_cnt_q == FRM_LAST) state_d = IDLE;
               else                       state_d = MUTE;
            end else if (tmo_cnt_q == TMO_LAST) begin
               terr_d = 1'b1;
`ifdef VGA_MODE_FALLBACK_EN
               if (!fb_q && (prev_q != mode_q)) begin
                  fb_d    = 1'b1;
                  pend_d  = prev_q;
                  state_d = HOLD;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end else begin
               state_d = MUTE;
            end
         end
         default: state_d = BOOT;
      endcase
`ifdef VGA_MODE_FALLBACK_EN
      if (state_d == IDLE) fb_d = 1'b0;
      else                 fb_d = fb_d;
`endif
   end

   // Counters restart on every state change; frame timeout restarts on each vsync edge
   always_comb begin
      if (state_d != state_q) begin
         set_cnt_d = '0;
         frm_cnt_d = '0;
         tmo_cnt_d = '0;
      end else begin
         set_cnt_d = set_cnt_q + SW'(1);
         tmo_cnt_d = vs_edge ? '0 : tmo_cnt_q + TW'(1);
         frm_cnt_d = (vs_edge && (state_q == MUTE)) ? frm_cnt_q + FW'(1) : frm_cnt_q;
      end
   end

   // Output decode from the next state so every output leaves a flop
   always_comb begin
      rdy_d  = (state_d == IDLE);
      busy_d = (state_d != IDLE);
      pix_d  = (state_d == IDLE);
      vrst_d = !(state_d inside {BOOT, HOLD, SETTLE});
   end

   // State, counter and output registers
   always_ff @(posedge clk_37m or negedge resetn) begin
      if (!resetn) begin
         state_q   <= BOOT;
         set_cnt_q <= '0;
         frm_cnt_q <= '0;
         tmo_cnt_q <= '0;
         pend_q    <= MODE_720P30;
         mode_q    <= MODE_720P30;
         terr_q    <= 1'b0;
         rdy_q     <= 1'b0;
         busy_q    <= 1'b1;
         pix_q     <= 1'b0;
         vrst_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         set_cnt_q <= set_cnt_d;
         frm_cnt_q <= frm_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         pend_q    <= pend_d;
         mode_q    <= mode_d;
         terr_q    <= terr_d;
         rdy_q     <= rdy_d;
         busy_q    <= busy_d;
         pix_q     <= pix_d;
         vrst_q    <= vrst_d;
      end
   end

`ifdef VGA_MODE_FALLBACK_EN
   // Previous mode and single-shot fallback flag
   always_ff @(posedge clk_37m or negedge resetn) begin
      if (!resetn) begin
         prev_q <= MODE_720P30;
         fb_q   <= 1'b0;
      end else begin
         prev_q <= prev_d;
         fb_q   <= fb_d;
      end
   end

   assign fallback_active = fb_q;
`endif

   assign req_ready   = rdy_q;
   assign busy        = busy_q;
   assign pix_en      = pix_q;
   assign vga_resetn  = vrst_q;
   assign mode_sel    = mode_q;
   assign timeout_err = terr_q;

endmodule
